// File: rtl/alu_fetch_pkg.sv
// ---------------------------------------------------------------------------
// alu_fetch_pkg
// Shared constants for the ALU operand-fetch stage: widths, addressing-mode
// codes and FSM state encoding.
// ---------------------------------------------------------------------------
package alu_fetch_pkg;

    localparam int unsigned AW = 16;    // internal address width
    localparam int unsigned DW = 8;     // data / index width
    localparam int unsigned MW = 3;     // addressing-mode width
    localparam int unsigned SW = 3;     // FSM state width

    // Addressing modes
    localparam logic [MW-1:0] MODE_IMM  = 3'd0;
    localparam logic [MW-1:0] MODE_ZP   = 3'd1;
    localparam logic [MW-1:0] MODE_ZPX  = 3'd2;
    localparam logic [MW-1:0] MODE_ABS  = 3'd3;
    localparam logic [MW-1:0] MODE_ABSX = 3'd4;
    localparam logic [MW-1:0] MODE_ABSY = 3'd5;
    localparam logic [MW-1:0] MODE_INDX = 3'd6;
    localparam logic [MW-1:0] MODE_INDY = 3'd7;

    // FSM states
    localparam logic [SW-1:0] ST_IDLE   = 3'd0;
    localparam logic [SW-1:0] ST_PTR_LO = 3'd1;
    localparam logic [SW-1:0] ST_PTR_HI = 3'd2;
    localparam logic [SW-1:0] ST_RD     = 3'd3;
    localparam logic [SW-1:0] ST_CAP    = 3'd4;
    localparam logic [SW-1:0] ST_OUT    = 3'd5;
    localparam logic [SW-1:0] ST_PEN    = 3'd6;

endpackage : alu_fetch_pkg

// File: rtl/alu_operand_fetch_ea_calc.sv
// ---------------------------------------------------------------------------
// ea_calc
// Combinational effective-address unit, shared by pointer and data address
// generation.
//   i_base       : base address (argument, or {ptr_hi, ptr_lo})
//   i_index      : index register value
//   i_mode       : addressing mode selecting the arithmetic
//   o_ea         : effective address
//   o_zp_next    : (o_ea[7:0] + 1) mod 256, the zero-page pointer high byte
//   o_page_cross : indexed EA high byte differs from base high byte
// ---------------------------------------------------------------------------
module ea_calc
    import alu_fetch_pkg::*;
(
    input  logic [AW-1:0] i_base,
    input  logic [DW-1:0] i_index,
    input  logic [MW-1:0] i_mode,
    output logic [AW-1:0] o_ea,
    output logic [DW-1:0] o_zp_next,
    output logic          o_page_cross
);

    logic [DW-1:0] w_zp_sum;
    logic [AW-1:0] w_abs_sum;

    // Zero-page sums wrap inside page 0; absolute sums wrap at 64K
    assign w_zp_sum  = i_base[DW-1:0] + i_index;
    assign w_abs_sum = i_base + AW'(i_index);

    always_comb begin
        o_ea         = '0;
        o_page_cross = 1'b0;
        case (i_mode)
            MODE_IMM:              o_ea = '0;
            MODE_ZP:               o_ea = {8'h00, i_base[DW-1:0]};
            MODE_ZPX, MODE_INDX:   o_ea = {8'h00, w_zp_sum};
            MODE_ABS:              o_ea = i_base;
            default: begin
                // ABSX, ABSY, INDY
                o_ea         = w_abs_sum;
                o_page_cross = (w_abs_sum[AW-1:DW] != i_base[AW-1:DW]);
            end
        endcase
    end

    assign o_zp_next = o_ea[DW-1:0] + 8'd1;

endmodule : ea_calc

// File: rtl/alu_operand_fetch.sv
// ---------------------------------------------------------------------------
// alu_operand_fetch
// Operand-fetch stage ahead of the ALU: resolves the effective address of a
// decoded instruction, reads the operand over a 1-cycle-latency memory bus
// and presents op/operand to the ALU with a one-cycle valid pulse.
//   clk, rst (sync, active-low)
//   req_valid/req_ready, req_op, req_mode, req_arg, x_reg, y_reg : request
//   mem_addr, mem_rd, mem_rdata                                 : memory bus
//   alu_valid, alu_op, alu_operand, alu_ea, page_cross          : ALU side
// Optional macro OPFETCH_PAGE_PENALTY_EN inserts a one-cycle PEN state on
// page-crossing ABSX/ABSY/INDY accesses.
// ---------------------------------------------------------------------------
module alu_operand_fetch
    import alu_fetch_pkg::*;
#(
    parameter int unsigned MEM_AW = 16,
    parameter int unsigned OPW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OPW-1:0]    req_op,
    input  logic [MW-1:0]     req_mode,
    input  logic [AW-1:0]     req_arg,
    input  logic [DW-1:0]     x_reg,
    input  logic [DW-1:0]     y_reg,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DW-1:0]     mem_rdata,
    output logic              alu_valid,
    output logic [OPW-1:0]    alu_op,
    output logic [DW-1:0]     alu_operand,
    output logic [MEM_AW-1:0] alu_ea,
    output logic              page_cross
);

`ifdef OPFETCH_PAGE_PENALTY_EN
    localparam bit PEN_EN = 1'b1;
`else
    localparam bit PEN_EN = 1'b0;
`endif

    // State and registered outputs
    logic [SW-1:0]  r_state,       w_state_nxt;
    logic           r_ready,       w_ready_nxt;
    logic           r_mem_rd,      w_mem_rd_nxt;
    logic [AW-1:0]  r_mem_addr,    w_mem_addr_nxt;
    logic           r_alu_valid,   w_alu_valid_nxt;
    logic [OPW-1:0] r_alu_op,      w_alu_op_nxt;
    logic [DW-1:0]  r_alu_operand, w_alu_operand_nxt;
    logic [AW-1:0]  r_alu_ea,      w_alu_ea_nxt;
    logic           r_page_cross,  w_page_cross_nxt;
    // Request context
    logic [OPW-1:0] r_op,          w_op_nxt;
    logic [MW-1:0]  r_mode,        w_mode_nxt;
    logic [DW-1:0]  r_y,           w_y_nxt;
    logic [DW-1:0]  r_ptr_hi,      w_ptr_hi_nxt;
    logic [DW-1:0]  r_ptr_lo,      w_ptr_lo_nxt;
    logic           r_ptr_phase,   w_ptr_phase_nxt;
    logic [AW-1:0]  r_ea,          w_ea_nxt;
    logic           r_pc,          w_pc_nxt;

    logic           w_accept;
    logic           w_ptr_resolve;
    logic [AW-1:0]  w_base;
    logic [DW-1:0]  w_index;
    logic [MW-1:0]  w_calc_mode;
    logic [AW-1:0]  w_ea;
    logic [DW-1:0]  w_zp_next;
    logic           w_pc;

    assign w_accept      = req_valid && r_ready;
    assign w_ptr_resolve = (r_state == ST_CAP) && r_ptr_phase;

    // EA unit input select: the incoming request, or the fetched pointer.
    // INDY's pointer is the plain zero-page byte; INDX's final EA is the
    // pointer itself, so it resolves as ABS.
    always_comb begin
        if (w_ptr_resolve) begin
            w_base      = {mem_rdata, r_ptr_lo};
            w_index     = r_y;
            w_calc_mode = (r_mode == MODE_INDY) ? MODE_INDY : MODE_ABS;
        end else begin
            w_base      = req_arg;
            w_index     = (req_mode == MODE_ABSY) ? y_reg : x_reg;
            w_calc_mode = (req_mode == MODE_INDY) ? MODE_ZP : req_mode;
        end
    end

    ea_calc u_ea_calc (
        .i_base       (w_base),
        .i_index      (w_index),
        .i_mode       (w_calc_mode),
        .o_ea         (w_ea),
        .o_zp_next    (w_zp_next),
        .o_page_cross (w_pc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_ready       <= 1'b1;
            r_mem_rd      <= 1'b0;
            r_mem_addr    <= '0;
            r_alu_valid   <= 1'b0;
            r_alu_op      <= '0;
            r_alu_operand <= '0;
            r_alu_ea      <= '0;
            r_page_cross  <= 1'b0;
            r_op          <= '0;
            r_mode        <= MODE_IMM;
            r_y           <= '0;
            r_ptr_hi      <= '0;
            r_ptr_lo      <= '0;
            r_ptr_phase   <= 1'b0;
            r_ea          <= '0;
            r_pc          <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ready       <= w_ready_nxt;
            r_mem_rd      <= w_mem_rd_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_alu_valid   <= w_alu_valid_nxt;
            r_alu_op      <= w_alu_op_nxt;
            r_alu_operand <= w_alu_operand_nxt;
            r_alu_ea      <= w_alu_ea_nxt;
            r_page_cross  <= w_page_cross_nxt;
            r_op          <= w_op_nxt;
            r_mode        <= w_mode_nxt;
            r_y           <= w_y_nxt;
            r_ptr_hi      <= w_ptr_hi_nxt;
            r_ptr_lo      <= w_ptr_lo_nxt;
            r_ptr_phase   <= w_ptr_phase_nxt;
            r_ea          <= w_ea_nxt;
            r_pc          <= w_pc_nxt;
        end
    end

    // Next-state and output logic
    always_comb begin
        w_state_nxt       = r_state;
        w_mem_rd_nxt      = 1'b0;
        w_mem_addr_nxt    = r_mem_addr;
        w_alu_valid_nxt   = 1'b0;
        w_alu_op_nxt      = r_alu_op;
        w_alu_operand_nxt = r_alu_operand;
        w_alu_ea_nxt      = r_alu_ea;
        w_page_cross_nxt  = r_page_cross;
        w_op_nxt          = r_op;
        w_mode_nxt        = r_mode;
        w_y_nxt           = r_y;
        w_ptr_hi_nxt      = r_ptr_hi;
        w_ptr_lo_nxt      = r_ptr_lo;
        w_ptr_phase_nxt   = r_ptr_phase;
        w_ea_nxt          = r_ea;
        w_pc_nxt          = r_pc;

        case (r_state)
            ST_IDLE, ST_OUT: begin
                w_state_nxt = ST_IDLE;
                if (w_accept) begin
                    w_op_nxt   = req_op;
                    w_mode_nxt = req_mode;
                    w_y_nxt    = y_reg;
                    w_ea_nxt   = w_ea;
                    w_pc_nxt   = w_pc;
                    case (req_mode)
                        MODE_IMM: begin
                            w_state_nxt       = ST_OUT;
                            w_alu_valid_nxt   = 1'b1;
                            w_alu_op_nxt      = req_op;
                            w_alu_operand_nxt = req_arg[DW-1:0];
                            w_alu_ea_nxt      = '0;
                            w_page_cross_nxt  = 1'b0;
                        end
                        MODE_INDX, MODE_INDY: begin
                            w_state_nxt     = ST_PTR_LO;
                            w_mem_rd_nxt    = 1'b1;
                            w_mem_addr_nxt  = w_ea;
                            w_ptr_hi_nxt    = w_zp_next;
                            w_ptr_phase_nxt = 1'b0;
                        end
                        default: begin
                            w_mem_addr_nxt = w_ea;
                            if (PEN_EN && w_pc) begin
                                w_state_nxt = ST_PEN;
                            end else begin
                                w_state_nxt  = ST_RD;
                                w_mem_rd_nxt = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_PTR_LO: begin
                // Pointer high byte stays in page 0
                w_state_nxt    = ST_PTR_HI;
                w_mem_rd_nxt   = 1'b1;
                w_mem_addr_nxt = {8'h00, r_ptr_hi};
            end
            ST_PTR_HI: begin
                w_state_nxt     = ST_CAP;
                w_ptr_lo_nxt    = mem_rdata;
                w_ptr_phase_nxt = 1'b1;
            end
            ST_CAP: begin
                if (r_ptr_phase) begin
                    // High pointer byte arrives now; resolve the data EA
                    w_ptr_phase_nxt = 1'b0;
                    w_ea_nxt        = w_ea;
                    w_pc_nxt        = w_pc;
                    w_mem_addr_nxt  = w_ea;
                    if (PEN_EN && w_pc) begin
                        w_state_nxt = ST_PEN;
                    end else begin
                        w_state_nxt  = ST_RD;
                        w_mem_rd_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt       = ST_OUT;
                    w_alu_valid_nxt   = 1'b1;
                    w_alu_op_nxt      = r_op;
                    w_alu_operand_nxt = mem_rdata;
                    w_alu_ea_nxt      = r_ea;
                    w_page_cross_nxt  = r_pc;
                end
            end
            ST_RD: begin
                w_state_nxt = ST_CAP;
            end
            ST_PEN: begin
                w_state_nxt  = ST_RD;
                w_mem_rd_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_ready_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_OUT);
    end

    assign req_ready   = r_ready;
    assign mem_rd      = r_mem_rd;
    assign mem_addr    = MEM_AW'(r_mem_addr);
    assign alu_valid   = r_alu_valid;
    assign alu_op      = r_alu_op;
    assign alu_operand = r_alu_operand;
    assign alu_ea      = MEM_AW'(r_alu_ea);
    assign page_cross  = r_page_cross;

endmodule : alu_operand_fetch

// File: tb/tb_alu_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_fetch
// Directed bench for alu_operand_fetch: a byte-array memory answers reads one
// cycle later; expected ALU results and expected read addresses are queued
// at stimulus time and checked as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_alu_operand_fetch;

`ifdef OPFETCH_PAGE_PENALTY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    localparam logic [2:0] M_IMM  = 3'd0;
    localparam logic [2:0] M_ZP   = 3'd1;
    localparam logic [2:0] M_ZPX  = 3'd2;
    localparam logic [2:0] M_ABS  = 3'd3;
    localparam logic [2:0] M_ABSX = 3'd4;
    localparam logic [2:0] M_ABSY = 3'd5;
    localparam logic [2:0] M_INDX = 3'd6;
    localparam logic [2:0] M_INDY = 3'd7;

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  opnd;
        logic [15:0] ea;
        logic        pc;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [2:0]  req_mode = '0;
    logic [15:0] req_arg = '0;
    logic [7:0]  x_reg = '0;
    logic [7:0]  y_reg = '0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = '0;
    logic        alu_valid;
    logic [3:0]  alu_op;
    logic [7:0]  alu_operand;
    logic [15:0] alu_ea;
    logic        page_cross;

    logic [7:0]  mem [0:65535];
    exp_t        expq[$];
    logic [15:0] rdq[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    alu_operand_fetch #(.MEM_AW(16), .OPW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_mode    (req_mode),
        .req_arg     (req_arg),
        .x_reg       (x_reg),
        .y_reg       (y_reg),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .alu_valid   (alu_valid),
        .alu_op      (alu_op),
        .alu_operand (alu_operand),
        .alu_ea      (alu_ea),
        .page_cross  (page_cross)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory with exactly one cycle of read latency
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: read addresses and ALU results in order
    always @(negedge clk) begin
        if (mem_rd === 1'b1) begin
            chk("rd_expected", 32'(rdq.size() != 0), 32'd1);
            if (rdq.size() != 0) chk("rd_addr", 32'(mem_addr), 32'(rdq.pop_front()));
        end
        if (alu_valid === 1'b1) begin
            chk("valid_expected", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) begin
                exp_t e;
                e = expq.pop_front();
                chk("alu_op", 32'(alu_op), 32'(e.op));
                chk("alu_operand", 32'(alu_operand), 32'(e.opnd));
                chk("alu_ea", 32'(alu_ea), 32'(e.ea));
                chk("page_cross", 32'(page_cross), 32'(e.pc));
                chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [2:0] mode, input logic [15:0] arg,
                        input logic [7:0] x, input logic [7:0] y, input logic [7:0] opnd,
                        input logic [15:0] ea, input logic pc, input int lat);
        exp_t e;
        int   n;
        @(negedge clk);
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_mode  = mode;
        req_arg   = arg;
        x_reg     = x;
        y_reg     = y;
        e.op = op; e.opnd = opnd; e.ea = ea; e.pc = pc; e.lat = lat;
        e.acc = cyc + 1;
        expq.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && expq.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", 32'(expq.size()), 32'd0);
        @(negedge clk);
        chk("valid_pulse", 32'(alu_valid), 32'd0);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h0010] = 8'h7E;
        mem[16'h1310] = 8'hA5;
        mem[16'h00FF] = 8'h34;
        mem[16'h0000] = 8'h12;
        mem[16'h1234] = 8'hC3;
        mem[16'h0040] = 8'hFF;
        mem[16'h0041] = 8'h00;
        mem[16'h0100] = 8'h5A;
        mem[16'h0033] = 8'h11;
        mem[16'h2000] = 8'h99;
        mem[16'h1205] = 8'h3C;
        mem[16'h0050] = 8'h00;
        mem[16'h0051] = 8'h30;
        mem[16'h3004] = 8'h77;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_alu_valid", 32'(alu_valid), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_operand", 32'(alu_operand), 32'd0);
        chk("rst_alu_ea", 32'(alu_ea), 32'd0);
        chk("rst_page_cross", 32'(page_cross), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);

        // IMM
        send(4'h6, M_IMM, 16'h0042, 8'h00, 8'h00, 8'h42, 16'h0000, 1'b0, 1);
        wait_idle();
        // ZPX, no wrap of the address past page 0
        rdq.push_back(16'h0010);
        send(4'h1, M_ZPX, 16'h00F0, 8'h20, 8'h00, 8'h7E, 16'h0010, 1'b0, 3);
        wait_idle();
        // ABSX with page cross
        rdq.push_back(16'h1310);
        send(4'h2, M_ABSX, 16'h12F0, 8'h20, 8'h00, 8'hA5, 16'h1310, 1'b1, 3 + PEN);
        wait_idle();
        // INDX with pointer wrap inside page 0
        rdq.push_back(16'h00FF); rdq.push_back(16'h0000); rdq.push_back(16'h1234);
        send(4'h3, M_INDX, 16'h00FE, 8'h01, 8'h00, 8'hC3, 16'h1234, 1'b0, 6);
        wait_idle();
        // INDY with page cross
        rdq.push_back(16'h0040); rdq.push_back(16'h0041); rdq.push_back(16'h0100);
        send(4'h4, M_INDY, 16'h0040, 8'h00, 8'h01, 8'h5A, 16'h0100, 1'b1, 6 + PEN);
        wait_idle();
        // ZP
        rdq.push_back(16'h0033);
        send(4'h5, M_ZP, 16'h0033, 8'h07, 8'h09, 8'h11, 16'h0033, 1'b0, 3);
        wait_idle();
        // ABS
        rdq.push_back(16'h2000);
        send(4'h7, M_ABS, 16'h2000, 8'h07, 8'h09, 8'h99, 16'h2000, 1'b0, 3);
        wait_idle();
        // ABSY wrapping $FFFF+1 to $0000
        rdq.push_back(16'h0000);
        send(4'h8, M_ABSY, 16'hFFFF, 8'h00, 8'h01, 8'h12, 16'h0000, 1'b1, 3 + PEN);
        wait_idle();
        // ABSX without page cross
        rdq.push_back(16'h1205);
        send(4'h9, M_ABSX, 16'h1200, 8'h05, 8'h00, 8'h3C, 16'h1205, 1'b0, 3);
        wait_idle();
        // INDY without page cross
        rdq.push_back(16'h0050); rdq.push_back(16'h0051); rdq.push_back(16'h3004);
        send(4'hA, M_INDY, 16'h0050, 8'h00, 8'h04, 8'h77, 16'h3004, 1'b0, 6);
        wait_idle();
        // Back-to-back IMM through OUT
        send(4'hB, M_IMM, 16'h0001, 8'h00, 8'h00, 8'h01, 16'h0000, 1'b0, 1);
        send(4'hC, M_IMM, 16'h00FE, 8'h00, 8'h00, 8'hFE, 16'h0000, 1'b0, 1);
        send(4'hD, M_IMM, 16'h1280, 8'h00, 8'h00, 8'h80, 16'h0000, 1'b0, 1);
        wait_idle();

        // Reset during PTR_HI of an INDY request: no result may appear
        rdq.push_back(16'h0040); rdq.push_back(16'h0041);
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'hE; req_mode = M_INDY; req_arg = 16'h0040; y_reg = 8'h01;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);              // PTR_LO
        @(negedge clk);              // PTR_HI
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_mem_rd", 32'(mem_rd), 32'd0);
        chk("abort_valid", 32'(alu_valid), 32'd0);
        chk("abort_reads_done", 32'(rdq.size()), 32'd0);
        repeat (8) @(negedge clk);
        send(4'hF, M_IMM, 16'h0055, 8'h00, 8'h00, 8'h55, 16'h0000, 1'b0, 1);
        wait_idle();
        chk("reads_left", 32'(rdq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_alu_operand_fetch
